sliding_window_3x3: RTL and testbench
=====================================

# sliding_window_3x3

Streaming 3x3 neighbourhood generator for the convolution datapath. It accepts a raster-order pixel stream one pixel per cycle over a valid/ready handshake and buffers the two previous image rows internally. For every fully populated 3x3 window it emits the nine pixels p0..p8 together with the window's top-left coordinate. A downstream stall holds the current window and back-pressures the source.

## Interface
- IMG_WIDTH, 10, pixels per row (>= 3)
- IMG_HEIGHT, 10, rows per frame (>= 3)
- PIX_W, 8, bits per pixel
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  in_pixel is valid
- in_pixel  in  PIX_W  raster-order pixel (row 0 col 0 first)
- in_ready  out  1  block can accept a pixel this cycle
- out_ready  in  1  downstream accepts the current window
- out_valid  out  1  p0..p8, out_row, out_col valid
- p0..p8  out  PIX_W each  window pixels; p0..p2 = top row left-to-right, p3..p5 = middle row, p6..p8 = bottom row
- out_row  out  $clog2(IMG_HEIGHT)  row of p0 (window top-left)
- out_col  out  $clog2(IMG_WIDTH)  column of p0
- frame_done  out  1  one-cycle pulse when the last window of a frame is accepted downstream

## Operation
- Clock and reset: one clock domain; reset is asynchronous and active-high.
- Accept: a pixel transfers when in_valid && in_ready. in_ready = !out_valid || out_ready, combinational.
- Position counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) track the accepted pixel. col wraps to 0 and row increments at end of row. Both return to 0 after pixel (IMG_HEIGHT-1, IMG_WIDTH-1) and the next frame begins without any control signal.
- Two line buffers of IMG_WIDTH x PIX_W hold rows r-1 and r-2. A 3x3 register array shifts in one column per accepted pixel: {row r-2, row r-1, incoming pixel}.
- State: FILL while row < 2, no output; RUN while row >= 2. A window is produced for an accepted pixel at (r,c) only if r >= 2 and c >= 2. Its contents are pixels (r-2..r, c-2..c), with out_row = r-2 and out_col = c-2.
- A window never mixes columns from different rows. Pixels at c = 0 and c = 1 produce no output but still shift into the window registers.
- Per frame: exactly (IMG_HEIGHT-2)*(IMG_WIDTH-2) windows, in raster order of top-left coordinate.
- Output register: loaded when a window-producing pixel is accepted. Held unchanged while out_valid && !out_ready. out_valid clears on out_ready when no new window is loaded in the same cycle.
- Arithmetic: no pixel arithmetic. Pixel values pass through bit-exact. Counters are unsigned with explicit wrap, never modulo 2^n.
- frame_done: asserted for one cycle in the cycle after the window at (IMG_HEIGHT-3, IMG_WIDTH-3) is accepted (out_valid && out_ready).

## Timing
- Reset values: out_valid=0, frame_done=0, p0..p8=0, out_row=0, out_col=0, counters=0. in_ready=1 after reset.
- Line buffer contents are not reset. They are always overwritten before being read.
- Latency: window appears on the outputs 1 cycle after the accepting edge of its bottom-right pixel.
- Throughput: 1 pixel/cycle sustained with out_ready held high. No bubbles at row or frame boundaries.
- Simultaneous events: out_ready with a new window-producing accept in the same cycle loads the new window and keeps out_valid=1.
- An accept of a non-window pixel (FILL, c<2) in the same cycle as out_ready clears out_valid.
- in_valid low: counters and windows freeze. Gaps of any length are legal.
- Reset mid-frame: aborts the frame. The next accepted pixel is treated as (0,0) and a full FILL phase is required again. No stale window is emitted.

## Test plan
- 4x4 frame, pixels 0..15, in_valid and out_ready held at 1 -> exactly 4 windows.
  - First window: p0..p8 = 0,1,2,4,5,6,8,9,10, row 0 col 0.
  - Last window: 5,6,7,9,10,11,13,14,15, row 1 col 1.
  - frame_done pulses once.
- Default 10x10 frame, pixel = row*10+col -> 64 windows.
  - Each window has p0 = out_row*10+out_col and p8 = p0+22.
  - No window has out_col > 7.
- 4x4 frame with out_ready low for 3 cycles after the first window -> in_ready=0 and outputs held stable throughout the stall. No pixel is lost; all 4 windows are correct.
- Random in_valid gaps (about 50%) over two back-to-back 10x10 frames -> second frame windows identical to the gap-free reference. frame_done pulses exactly twice.
- Assert rst after 25 pixels of a 10x10 frame, then stream a full frame -> out_valid=0 immediately. The first window after reset is pixels (0..2, 0..2) of the new frame.

Source files
------------

// File: rtl/sliding_window_3x3_if.sv
// Pixel-in / window-out stream bundle for sliding_window_3x3.
// The slave modport is the block side; the master modport is the source/sink side.
interface sliding_window_3x3_if #(
    parameter int unsigned IMG_WIDTH  = 10,
    parameter int unsigned IMG_HEIGHT = 10,
    parameter int unsigned PIX_W      = 8
);
    localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);
    localparam int unsigned COL_W = $clog2(IMG_WIDTH);

    logic             in_valid;
    logic [PIX_W-1:0] in_pixel;
    logic             in_ready;
    logic             out_ready;
    logic             out_valid;
    logic [PIX_W-1:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;
    logic [ROW_W-1:0] out_row;
    logic [COL_W-1:0] out_col;
    logic             frame_done;

    modport master (
        output in_valid, in_pixel, out_ready,
        input  in_ready, out_valid, p0, p1, p2, p3, p4, p5, p6, p7, p8,
        input  out_row, out_col, frame_done
    );

    modport slave (
        input  in_valid, in_pixel, out_ready,
        output in_ready, out_valid, p0, p1, p2, p3, p4, p5, p6, p7, p8,
        output out_row, out_col, frame_done
    );
endinterface

// File: rtl/sliding_window_3x3.sv
// Streaming 3x3 neighbourhood generator: two line buffers feed a 3x3 shift array that
// doubles as the output register, emitting one window per accepted bottom-right pixel.
module sliding_window_3x3 #(
    parameter int unsigned IMG_WIDTH  = 10,
    parameter int unsigned IMG_HEIGHT = 10,
    parameter int unsigned PIX_W      = 8
) (
    input logic                clk,
    input logic                rst,
    sliding_window_3x3_if.slave io_win
);
    localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);
    localparam int unsigned COL_W = $clog2(IMG_WIDTH);

    localparam logic [ROW_W-1:0] ROW_LAST     = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_LAST     = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_WIN_LAST = ROW_W'(IMG_HEIGHT - 3);
    localparam logic [COL_W-1:0] COL_WIN_LAST = COL_W'(IMG_WIDTH - 3);

    typedef enum logic {StFill, StRun} state_e;

    state_e           r_state, w_state_next;
    logic [ROW_W-1:0] r_row, w_row_next;
    logic [COL_W-1:0] r_col, w_col_next;

    logic [PIX_W-1:0] r_lb1 [IMG_WIDTH];
    logic [PIX_W-1:0] r_lb2 [IMG_WIDTH];
    logic [PIX_W-1:0] r_win [3][3];

    logic             r_out_valid;
    logic [ROW_W-1:0] r_out_row;
    logic [COL_W-1:0] r_out_col;
    logic             r_frame_done;

    logic w_in_ready;
    logic w_accept;
    logic w_win_load;

    assign w_in_ready = !r_out_valid || io_win.out_ready;
    assign w_accept   = io_win.in_valid && w_in_ready;

    always_comb begin
        w_state_next = r_state;
        w_row_next   = r_row;
        w_col_next   = r_col;
        w_win_load   = 1'b0;
        if (w_accept) begin
            w_win_load = (r_state == StRun) && (r_col >= COL_W'(2));
            if (r_col == COL_LAST) begin
                w_col_next = '0;
                w_row_next = (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
            end else begin
                w_col_next = r_col + COL_W'(1);
            end
            w_state_next = (w_row_next >= ROW_W'(2)) ? StRun : StFill;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StFill;
            r_row        <= '0;
            r_col        <= '0;
            r_out_valid  <= 1'b0;
            r_out_row    <= '0;
            r_out_col    <= '0;
            r_frame_done <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    r_win[i][j] <= '0;
                end
            end
        end else begin
            r_state <= w_state_next;
            r_row   <= w_row_next;
            r_col   <= w_col_next;
            // Every accept shifts a column in, so c=0/1 pixels prime the array for c=2.
            if (w_accept) begin
                for (int i = 0; i < 3; i++) begin
                    r_win[i][0] <= r_win[i][1];
                    r_win[i][1] <= r_win[i][2];
                end
                r_win[0][2] <= r_lb2[r_col];
                r_win[1][2] <= r_lb1[r_col];
                r_win[2][2] <= io_win.in_pixel;
            end
            if (w_win_load) begin
                r_out_valid <= 1'b1;
                r_out_row   <= r_row - ROW_W'(2);
                r_out_col   <= r_col - COL_W'(2);
            end else if (io_win.out_ready) begin
                r_out_valid <= 1'b0;
            end
            r_frame_done <= r_out_valid && io_win.out_ready &&
                            (r_out_row == ROW_WIN_LAST) && (r_out_col == COL_WIN_LAST);
        end
    end

    // Line buffers are write-before-read safe: a column is always rewritten before reuse.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb2[r_col] <= r_lb1[r_col];
            r_lb1[r_col] <= io_win.in_pixel;
        end
    end

    assign io_win.in_ready   = w_in_ready;
    assign io_win.out_valid  = r_out_valid;
    assign io_win.out_row    = r_out_row;
    assign io_win.out_col    = r_out_col;
    assign io_win.frame_done = r_frame_done;
    assign io_win.p0 = r_win[0][0];
    assign io_win.p1 = r_win[0][1];
    assign io_win.p2 = r_win[0][2];
    assign io_win.p3 = r_win[1][0];
    assign io_win.p4 = r_win[1][1];
    assign io_win.p5 = r_win[1][2];
    assign io_win.p6 = r_win[2][0];
    assign io_win.p7 = r_win[2][1];
    assign io_win.p8 = r_win[2][2];
endmodule

// File: tb/tb_sliding_window_3x3.sv
// Bench for sliding_window_3x3: a 4x4 and a 10x10 instance checked against a frame-memory
// scoreboard, plus fixed window tables, stall, gap, and mid-frame reset sequences.
module tb_sliding_window_3x3;
    typedef struct packed {
        logic [71:0] pix;
        logic [3:0]  row;
        logic [3:0]  col;
    } win_t;

    typedef struct {
        logic [71:0] pix;
        int          row;
        int          col;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       in_valid   [2];
    logic [7:0] in_pixel   [2];
    logic       out_ready  [2];
    logic       in_ready   [2];
    logic       out_valid  [2];
    logic       frame_done [2];
    logic [71:0] obs_pix   [2];
    logic [3:0] obs_row    [2];
    logic [3:0] obs_col    [2];

    sliding_window_3x3_if #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .PIX_W(8)) if_s ();
    sliding_window_3x3_if #(.IMG_WIDTH(10), .IMG_HEIGHT(10), .PIX_W(8)) if_b ();

    sliding_window_3x3 #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .PIX_W(8)) u_small (
        .clk    (clk),
        .rst    (rst),
        .io_win (if_s)
    );

    sliding_window_3x3 #(.IMG_WIDTH(10), .IMG_HEIGHT(10), .PIX_W(8)) u_big (
        .clk    (clk),
        .rst    (rst),
        .io_win (if_b)
    );

    assign if_s.in_valid  = in_valid[0];
    assign if_s.in_pixel  = in_pixel[0];
    assign if_s.out_ready = out_ready[0];
    assign if_b.in_valid  = in_valid[1];
    assign if_b.in_pixel  = in_pixel[1];
    assign if_b.out_ready = out_ready[1];

    assign in_ready[0]   = if_s.in_ready;
    assign out_valid[0]  = if_s.out_valid;
    assign frame_done[0] = if_s.frame_done;
    assign obs_pix[0]    = {if_s.p8, if_s.p7, if_s.p6, if_s.p5, if_s.p4,
                            if_s.p3, if_s.p2, if_s.p1, if_s.p0};
    assign obs_row[0]    = 4'(if_s.out_row);
    assign obs_col[0]    = 4'(if_s.out_col);
    assign in_ready[1]   = if_b.in_ready;
    assign out_valid[1]  = if_b.out_valid;
    assign frame_done[1] = if_b.frame_done;
    assign obs_pix[1]    = {if_b.p8, if_b.p7, if_b.p6, if_b.p5, if_b.p4,
                            if_b.p3, if_b.p2, if_b.p1, if_b.p0};
    assign obs_row[1]    = if_b.out_row;
    assign obs_col[1]    = if_b.out_col;

    int checks = 0;
    int errors = 0;

    win_t q0[$];
    win_t q1[$];
    win_t log0[$];
    logic [7:0] m_img [2][10][10];
    int m_row [2];
    int m_col [2];
    int dim [2] = '{4, 10};
    int win_cnt [2];
    int fd_cnt [2];
    bit cap_first = 1'b0;
    win_t first_win;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] pk(input int a0, input int a1, input int a2,
                                       input int a3, input int a4, input int a5,
                                       input int a6, input int a7, input int a8);
        return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    function automatic void model_accept(input int d, input logic [7:0] v);
        int r;
        int c;
        win_t e;
        r = m_row[d];
        c = m_col[d];
        m_img[d][r][c] = v;
        if (r >= 2 && c >= 2) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    e.pix[8*(3*i+j) +: 8] = m_img[d][r-2+i][c-2+j];
                end
            end
            e.row = 4'(r - 2);
            e.col = 4'(c - 2);
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        if (c == dim[d] - 1) begin
            m_col[d] = 0;
            m_row[d] = (r == dim[d] - 1) ? 0 : r + 1;
        end else begin
            m_col[d] = c + 1;
        end
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input int d, input logic [7:0] v);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        in_valid[d] = 1'b1;
        in_pixel[d] = v;
        while (!done) begin
            @(negedge clk);
            if (in_ready[d]) begin
                model_accept(d, v);
                done = 1'b1;
            end else if (++n > 50) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout dut%0d: in_ready stuck at 0, required 1", d);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid[d] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        win_t got;
        win_t exp;
        for (int d = 0; d < 2; d++) begin
            if (!rst && frame_done[d]) fd_cnt[d]++;
            if (!rst && out_valid[d] && out_ready[d]) begin
                got.pix = obs_pix[d];
                got.row = obs_row[d];
                got.col = obs_col[d];
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_win dut%0d: got %h expected none", d, got);
                end else begin
                    exp = (d == 0) ? q0.pop_front() : q1.pop_front();
                    check($sformatf("win_dut%0d_n%0d", d, win_cnt[d]), got, exp);
                end
                if (d == 0) log0.push_back(got);
                if (d == 1) begin
                    check($sformatf("col_range_n%0d", win_cnt[1]), 80'(got.col <= 4'd7), 80'd1);
                    if (cap_first) begin
                        first_win = got;
                        cap_first = 1'b0;
                    end
                end
                win_cnt[d]++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [4];
        logic [79:0] snap;
        int   base_cnt;
        logic [71:0] exp_first;

        tbl[0] = '{pk(0, 1, 2, 4, 5, 6, 8, 9, 10),     0, 0};
        tbl[1] = '{pk(1, 2, 3, 5, 6, 7, 9, 10, 11),    0, 1};
        tbl[2] = '{pk(4, 5, 6, 8, 9, 10, 12, 13, 14),  1, 0};
        tbl[3] = '{pk(5, 6, 7, 9, 10, 11, 13, 14, 15), 1, 1};

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            in_pixel[d]  = '0;
            out_ready[d] = 1'b1;
            m_row[d]     = 0;
            m_col[d]     = 0;
            win_cnt[d]   = 0;
            fd_cnt[d]    = 0;
        end
        #12;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_out_valid%0d", d), 80'(out_valid[d]), 80'd0);
            check($sformatf("rst_in_ready%0d", d), 80'(in_ready[d]), 80'd1);
            check($sformatf("rst_pix%0d", d), 80'(obs_pix[d]), 80'd0);
            check($sformatf("rst_row%0d", d), 80'(obs_row[d]), 80'd0);
            check($sformatf("rst_col%0d", d), 80'(obs_col[d]), 80'd0);
            check($sformatf("rst_frame_done%0d", d), 80'(frame_done[d]), 80'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);

        // 4x4 frame, no stalls.
        log0.delete();
        for (int i = 0; i < 16; i++) send(0, 8'(i));
        idle(4);
        check("t1_win_count", 80'(log0.size()), 80'd4);
        for (int i = 0; i < 4; i++) begin
            if (log0.size() > i) begin
                check($sformatf("t1_tbl%0d_pix", i), 80'(log0[i].pix), 80'(tbl[i].pix));
                check($sformatf("t1_tbl%0d_row", i), 80'(log0[i].row), 80'(tbl[i].row));
                check($sformatf("t1_tbl%0d_col", i), 80'(log0[i].col), 80'(tbl[i].col));
            end
        end
        check("t1_frame_done", 80'(fd_cnt[0]), 80'd1);

        // 4x4 frame with a 3-cycle downstream stall on the first window.
        log0.delete();
        fork
            begin
                for (int i = 0; i < 16; i++) send(0, 8'(i));
            end
            begin
                int n;
                n = 0;
                while (!out_valid[0] && n < 100) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                check("t3_saw_window", 80'(out_valid[0]), 80'd1);
                out_ready[0] = 1'b0;
                snap = {obs_pix[0], obs_row[0], obs_col[0]};
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check($sformatf("t3_in_ready_c%0d", k), 80'(in_ready[0]), 80'd0);
                    check($sformatf("t3_out_valid_c%0d", k), 80'(out_valid[0]), 80'd1);
                    check($sformatf("t3_hold_c%0d", k), {obs_pix[0], obs_row[0], obs_col[0]},
                          snap);
                end
                @(posedge clk);
                #1;
                out_ready[0] = 1'b1;
            end
        join
        idle(4);
        check("t3_win_count", 80'(log0.size()), 80'd4);
        for (int i = 0; i < 4; i++) begin
            if (log0.size() > i) begin
                check($sformatf("t3_tbl%0d_pix", i), 80'(log0[i].pix), 80'(tbl[i].pix));
                check($sformatf("t3_tbl%0d_rc", i), 80'({log0[i].row, log0[i].col}),
                      80'({4'(tbl[i].row), 4'(tbl[i].col)}));
            end
        end
        check("t3_frame_done", 80'(fd_cnt[0]), 80'd2);

        // Two back-to-back 10x10 frames with random input gaps.
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < 10; r++) begin
                for (int c = 0; c < 10; c++) begin
                    if ($urandom_range(1, 0) == 1) idle($urandom_range(3, 1));
                    send(1, 8'(r * 10 + c));
                end
            end
        end
        idle(5);
        check("t4_win_count", 80'(win_cnt[1]), 80'd128);
        check("t4_frame_done", 80'(fd_cnt[1]), 80'd2);
        check("t4_queue_empty", 80'(q1.size()), 80'd0);

        // Mid-frame reset after 25 pixels, then a full fresh frame.
        for (int i = 0; i < 25; i++) send(1, 8'(i));
        rst = 1'b1;
        #1;
        check("t5_rst_out_valid", 80'(out_valid[1]), 80'd0);
        check("t5_rst_frame_done", 80'(frame_done[1]), 80'd0);
        check("t5_rst_pix", 80'(obs_pix[1]), 80'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q1.delete();
        m_row[1] = 0;
        m_col[1] = 0;
        base_cnt = win_cnt[1];
        cap_first = 1'b1;
        for (int r = 0; r < 10; r++) begin
            for (int c = 0; c < 10; c++) send(1, 8'(100 + r * 10 + c));
        end
        idle(5);
        for (int k = 0; k < 9; k++) exp_first[8*k +: 8] = 8'(100 + (k / 3) * 10 + (k % 3));
        check("t5_first_pix", 80'(first_win.pix), 80'(exp_first));
        check("t5_first_rc", 80'({first_win.row, first_win.col}), 80'd0);
        check("t5_win_count", 80'(win_cnt[1] - base_cnt), 80'd64);
        check("t5_frame_done", 80'(fd_cnt[1]), 80'd3);
        check("t5_queue_empty", 80'(q1.size()), 80'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
